debounce_edge: RTL
==================

Name: debounce_edge

Overview:
- Downstream consumer of the two-flop input synchroniser (`sync`); takes its already-synchronised `dout` as `din`.
- Rejects pulses shorter than STABLE_CYCLES clocks and produces a clean debounced level.
- Emits single-cycle rise/fall strobes, flags aborted transitions, and keeps a running count of accepted rising edges for software/test readout.

Parameters:
- STABLE_CYCLES, 4, consecutive identical samples required to accept a transition; legal range 2..65535, elaboration error outside it.
- CNT_W, 16, width of the internal stability counter; must satisfy 2**CNT_W > STABLE_CYCLES.
- EVT_W, 8, width of the rising-edge event counter.
- RESET_LEVEL, 0, debounced level and FSM stable state entered on reset (0 or 1).

Ports:
- clock  in  1  single system clock, all logic on posedge.
- reset_n  in  1  asynchronous, active-low reset; asserts immediately, releases synchronously to clock.
- din  in  1  synchronised input (from sync.dout); no further metastability handling here.
- clear  in  1  synchronous clear of evt_count, active high.
- level  out  1  debounced level, registered.
- rise  out  1  one-cycle pulse when level goes 0->1.
- fall  out  1  one-cycle pulse when level goes 1->0.
- glitch  out  1  one-cycle pulse when a pending transition is aborted.
- evt_count  out  EVT_W  count of accepted rising edges, wraps.

Behaviour:
Reset values:
- level=RESET_LEVEL; rise=fall=glitch=0; evt_count=0; stability counter=0.
- FSM = S_LOW if RESET_LEVEL==0, else S_HIGH.
- Reset asserted mid-transition discards the pending transition with no strobes.

FSM states: S_LOW, S_L2H, S_HIGH, S_H2L; all outputs registered.
- S_LOW, din=1: go to S_L2H, cnt<=1. din=0: stay.
- S_L2H, din=0: go to S_LOW, cnt<=0, glitch<=1.
- S_L2H, din=1 and cnt==STABLE_CYCLES-1: go to S_HIGH, level<=1, rise<=1, cnt<=0.
- S_L2H, din=1 otherwise: cnt<=cnt+1.
- S_HIGH and S_H2L mirror S_LOW and S_L2H with polarity inverted; the accepting edge drives level<=0 and fall<=1.

Latency:
- din first sampled high at edge k and held high through edge k+STABLE_CYCLES-1.
- level and rise go high after edge k+STABLE_CYCLES-1, i.e. STABLE_CYCLES clocks after the first sample.

Strobes:
- rise, fall and glitch are each high for exactly one cycle and are mutually exclusive.
- Default is 0 every cycle unless set by the FSM.

evt_count:
- Increments by 1 on the cycle rise is asserted.
- Wraps from 2**EVT_W-1 to 0; no saturation.
- clear=1 alone: evt_count<=0.
- clear and an accepting rising edge on the same edge: evt_count<=1 (clear, then count).
- clear has no effect on the FSM or level.

Boundary conditions:
- din toggling every cycle: never accepted; glitch pulses on each abort; level unchanged.
- Pulse exactly STABLE_CYCLES-1 samples long: rejected with glitch=1.
- Pulse exactly STABLE_CYCLES samples long: accepted.
- Return to the original level on the same edge that would have reached count STABLE_CYCLES-1 is impossible by construction: the din sample decides.

Decomposition:
- No shared package needed.
- State encoding as localparams inside the module (2-bit binary).
- One natural sub-module: event_counter (EVT_W, synchronous clear, enable, wrap), instantiated once; reusable by later blocks.
- FSM, stability counter and strobe registers stay in debounce_edge.

Test Plan:
All scenarios use a 40 ns clock and STABLE_CYCLES=3, din driven through the real sync instance.
1. Reset: hold reset_n=0 with din=1 -> level=0, rise=fall=glitch=0, evt_count=0; release reset, din=1 held -> rise pulses once, 3 clocks after the first din=1 sample at the debounce input; evt_count=1.
2. Short pulse: din high for 2 sampled clocks then low -> no rise, one glitch pulse; level stays 0; evt_count unchanged.
3. Sub-period glitches: din wiggles of 2-5 ns between clock edges -> no rise, no fall, level stable.
4. Full cycle: din high 5 clocks then low 5 clocks -> rise once, then fall 3 clocks after the first low sample; evt_count +1.
5. Wrap and clear: EVT_W=8, 256 accepted rises -> evt_count returns to 0; clear asserted on the same edge as a rise -> evt_count=1.
6. Reset mid-transition: reset_n pulled low while in S_L2H with cnt=1 -> outputs at reset values immediately (asynchronous); no rise or glitch emitted.

Source files
------------

// File: rtl/event_counter.sv
// event_counter: wrapping up-counter with synchronous clear and count enable.
// When clear and en coincide the clear wins first and the event is still
// counted, so the counter lands on 1 rather than 0.
//
// Ports:
//   clock    in   system clock, posedge
//   reset_n  in   asynchronous active-low reset
//   clear    in   synchronous clear, active high
//   en       in   count one event this cycle
//   count    out  EVT_W-bit running count, wraps at 2**EVT_W
module event_counter #(
  parameter int EVT_W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             en,
  output logic [EVT_W-1:0] count
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)   count <= '0;
    else if (clear) count <= en ? EVT_W'(1) : '0;
    else if (en)    count <= count + EVT_W'(1);
  end

endmodule

// File: rtl/debounce_edge.sv
// debounce_edge: debounces an already-synchronised input. A new level is
// accepted only after STABLE_CYCLES consecutive identical samples; shorter
// excursions are dropped and flagged with a glitch strobe. Accepted edges
// produce one-cycle rise/fall strobes, and rising edges are counted.
//
// Ports:
//   clock      in   system clock, posedge
//   reset_n    in   asynchronous active-low reset
//   din        in   synchronised input
//   clear      in   synchronous clear of evt_count
//   level      out  debounced level
//   rise       out  one-cycle pulse on accepted 0->1
//   fall       out  one-cycle pulse on accepted 1->0
//   glitch     out  one-cycle pulse when a pending transition aborts
//   evt_count  out  count of accepted rising edges, wraps
module debounce_edge #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 16,
  parameter int EVT_W         = 8,
  parameter int RESET_LEVEL   = 0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             din,
  input  logic             clear,
  output logic             level,
  output logic             rise,
  output logic             fall,
  output logic             glitch,
  output logic [EVT_W-1:0] evt_count
);

  if (STABLE_CYCLES < 2 || STABLE_CYCLES > 65535) begin : g_bad_stable
    $error("debounce_edge: STABLE_CYCLES must be in 2..65535");
  end
  if ((64'd1 << CNT_W) <= 64'(STABLE_CYCLES)) begin : g_bad_cnt_w
    $error("debounce_edge: CNT_W too narrow for STABLE_CYCLES");
  end

  localparam logic [1:0] S_LOW  = 2'd0;
  localparam logic [1:0] S_L2H  = 2'd1;
  localparam logic [1:0] S_HIGH = 2'd2;
  localparam logic [1:0] S_H2L  = 2'd3;

  localparam logic             RST_LVL   = (RESET_LEVEL != 0);
  localparam logic [1:0]       RST_STATE = RST_LVL ? S_HIGH : S_LOW;
  // cnt already holds the number of matching samples seen before this edge,
  // so the edge that sees cnt == LAST supplies the final required sample.
  localparam logic [CNT_W-1:0] LAST      = CNT_W'(STABLE_CYCLES - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             accept_rise;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= RST_STATE;
      cnt    <= '0;
      level  <= RST_LVL;
      rise   <= 1'b0;
      fall   <= 1'b0;
      glitch <= 1'b0;
    end else begin
      rise   <= 1'b0;
      fall   <= 1'b0;
      glitch <= 1'b0;
      case (state)
        S_LOW: if (din) begin
          state <= S_L2H;
          cnt   <= CNT_W'(1);
        end
        S_L2H: if (!din) begin
          state  <= S_LOW;
          cnt    <= '0;
          glitch <= 1'b1;
        end else if (cnt == LAST) begin
          state <= S_HIGH;
          level <= 1'b1;
          rise  <= 1'b1;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
        S_HIGH: if (!din) begin
          state <= S_H2L;
          cnt   <= CNT_W'(1);
        end
        S_H2L: if (din) begin
          state  <= S_HIGH;
          cnt    <= '0;
          glitch <= 1'b1;
        end else if (cnt == LAST) begin
          state <= S_LOW;
          level <= 1'b0;
          fall  <= 1'b1;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
        default: begin
          state <= RST_STATE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Count on the accepting edge itself so evt_count moves with rise.
  assign accept_rise = (state == S_L2H) && din && (cnt == LAST);

  event_counter #(.EVT_W(EVT_W)) u_evt (
    .clock  (clock),
    .reset_n(reset_n),
    .clear  (clear),
    .en     (accept_rise),
    .count  (evt_count)
  );

endmodule
